// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller
//  Description : Exception entry/exit sequencer. Takes ECALL / illegal
//                instruction traps into the handler ROM, returns on MRET to
//                mepc+4, and halts the core on a double fault or when the
//                handler strays outside its ROM window.
//  Revision    : 1.0  initial release
// ============================================================================
module trap_controller #(
    parameter logic [31:0] HANDLER_BASE  = 32'h1c09_0000,
    parameter logic [31:0] HANDLER_SIZE  = 32'h0000_0090,
    parameter logic [31:0] ECALL_CAUSE   = 32'd11,
    parameter logic [31:0] ILLEGAL_CAUSE = 32'd2,
    parameter int          COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Retire_i,
    input  logic [31:0]        Pc_i,
    input  logic               IsEcall_i,
    input  logic               IsMret_i,
    input  logic               IsIllegal_i,
    output logic               Redirect_o,
    output logic [31:0]        RedirectPc_o,
    output logic               InHandler_o,
    output logic [31:0]        Mepc_o,
    output logic [31:0]        Mcause_o,
    output logic               Halt_o,
    output logic [COUNT_W-1:0] TrapCount_o
);

    // Exclusive upper bound of the handler ROM window (must not overflow).
    localparam logic [31:0] c_HANDLER_END = HANDLER_BASE + HANDLER_SIZE;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HANDLER = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [31:0]        mepc_q;
    logic [31:0]        mcause_q;
    logic [COUNT_W-1:0] count_q;

    logic               w_in_range;
    logic               w_take_trap;
    logic               w_do_return;
    logic [31:0]        w_cause;

    assign w_in_range = (Pc_i >= HANDLER_BASE) && (Pc_i < c_HANDLER_END);

    // Illegal encoding outranks ECALL; a lone MRET outside the handler is
    // treated as illegal as well.
    assign w_cause = IsIllegal_i ? ILLEGAL_CAUSE :
                     IsEcall_i   ? ECALL_CAUSE   : ILLEGAL_CAUSE;

    // Event decode: which architectural action the retiring instruction causes.
    always_comb begin
        w_take_trap = 1'b0;
        w_do_return = 1'b0;
        if (Retire_i) begin
            case (state_q)
                ST_RUN: begin
                    w_take_trap = IsIllegal_i | IsEcall_i | IsMret_i;
                end
                ST_HANDLER: begin
                    w_do_return = IsMret_i & ~IsIllegal_i & ~IsEcall_i & w_in_range;
                end
                default: begin
                    w_take_trap = 1'b0;
                    w_do_return = 1'b0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_take_trap) begin
                    state_d = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (Retire_i) begin
                    // Nested trap or escape from the ROM window is fatal.
                    if (IsIllegal_i || IsEcall_i || !w_in_range) begin
                        state_d = ST_FAULT;
                    end else if (IsMret_i) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Combinational redirect toward the handler or back to mepc+4.
    always_comb begin
        Redirect_o   = 1'b0;
        RedirectPc_o = 32'd0;
        if (!rst) begin
            if (w_take_trap) begin
                Redirect_o   = 1'b1;
                RedirectPc_o = HANDLER_BASE;
            end else if (w_do_return) begin
                Redirect_o   = 1'b1;
                RedirectPc_o = mepc_q + 32'd4;
            end
        end
    end

    // Trap CSRs and saturating trap counter, written only on trap entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
            count_q  <= '0;
        end else if (w_take_trap) begin
            mepc_q   <= Pc_i;
            mcause_q <= w_cause;
            if (!(&count_q)) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign InHandler_o = (state_q == ST_HANDLER);
    assign Halt_o      = (state_q == ST_FAULT);
    assign Mepc_o      = mepc_q;
    assign Mcause_o    = mcause_q;
    assign TrapCount_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_controller
//  Description : Self-checking bench for trap_controller. A behavioural model
//                is compared against the DUT on every falling edge; directed
//                literal checks pin the model, then random traffic follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trap_controller;

    localparam logic [31:0] BASE = 32'h1c09_0000;
    localparam logic [31:0] SIZE = 32'h0000_0090;
    localparam int          CW   = 8;

    logic          clk;
    logic          rst;
    logic          retire;
    logic [31:0]   pc;
    logic          ecall;
    logic          mret;
    logic          ill;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          in_handler;
    logic [31:0]   mepc;
    logic [31:0]   mcause;
    logic          halt;
    logic [CW-1:0] trap_count;

    int n_checks = 0;
    int n_err    = 0;

    // Model state, held at the architectural level.
    bit          m_hand;
    bit          m_halt;
    logic [31:0] m_mepc;
    logic [31:0] m_cause;
    int          m_cnt;

    trap_controller #(
        .HANDLER_BASE  (BASE),
        .HANDLER_SIZE  (SIZE),
        .ECALL_CAUSE   (32'd11),
        .ILLEGAL_CAUSE (32'd2),
        .COUNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Retire_i     (retire),
        .Pc_i         (pc),
        .IsEcall_i    (ecall),
        .IsMret_i     (mret),
        .IsIllegal_i  (ill),
        .Redirect_o   (redirect),
        .RedirectPc_o (redirect_pc),
        .InHandler_o  (in_handler),
        .Mepc_o       (mepc),
        .Mcause_o     (mcause),
        .Halt_o       (halt),
        .TrapCount_o  (trap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and per-cycle comparison.
    always @(negedge clk) begin
        bit          e_red;
        logic [31:0] e_rpc;
        bit          oob;
        e_red = 1'b0;
        e_rpc = 32'd0;
        if (rst) begin
            m_hand = 0; m_halt = 0; m_mepc = 0; m_cause = 0; m_cnt = 0;
            chk("rst_redirect", {31'd0, redirect}, 32'd0);
            chk("rst_rpc", redirect_pc, 32'd0);
            chk("rst_inhandler", {31'd0, in_handler}, 32'd0);
            chk("rst_halt", {31'd0, halt}, 32'd0);
            chk("rst_mepc", mepc, 32'd0);
            chk("rst_mcause", mcause, 32'd0);
            chk("rst_count", 32'(trap_count), 32'd0);
        end else begin
            chk("m_inhandler", {31'd0, in_handler}, {31'd0, m_hand});
            chk("m_halt", {31'd0, halt}, {31'd0, m_halt});
            chk("m_mepc", mepc, m_mepc);
            chk("m_mcause", mcause, m_cause);
            chk("m_count", 32'(trap_count), 32'(m_cnt));
            if (m_halt || !retire) begin
                // nothing happens
            end else if (!m_hand) begin
                if (ill || ecall || mret) begin
                    e_red   = 1'b1;
                    e_rpc   = BASE;
                    m_mepc  = pc;
                    m_cause = ill ? 32'd2 : (ecall ? 32'd11 : 32'd2);
                    if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
                    m_hand  = 1;
                end
            end else begin
                oob = (pc < BASE) || (pc >= BASE + SIZE);
                if (ill || ecall || oob) begin
                    m_hand = 0;
                    m_halt = 1;
                end else if (mret) begin
                    e_red  = 1'b1;
                    e_rpc  = m_mepc + 32'd4;
                    m_hand = 0;
                end
            end
            chk("m_redirect", {31'd0, redirect}, {31'd0, e_red});
            chk("m_rpc", redirect_pc, e_rpc);
        end
    end

    task automatic drive(input bit r, input logic [31:0] p, input bit e, input bit m, input bit i);
        @(posedge clk);
        #1;
        retire = r; pc = p; ecall = e; mret = m; ill = i;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        retire = 1'b0; ecall = 1'b0; mret = 1'b0; ill = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        retire = 1'b0; pc = 32'h0; ecall = 1'b0; mret = 1'b0; ill = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("lit_reset_inhandler", {31'd0, in_handler}, 32'd0);
        chk("lit_reset_count", 32'(trap_count), 32'd0);

        // ECALL from RUN
        drive(1, 32'h40, 1, 0, 0); #1;
        chk("lit_ecall_redirect", {31'd0, redirect}, 32'd1);
        chk("lit_ecall_rpc", redirect_pc, 32'h1c09_0000);
        idle();
        chk("lit_ecall_inhandler", {31'd0, in_handler}, 32'd1);
        chk("lit_ecall_mepc", mepc, 32'h40);
        chk("lit_ecall_mcause", mcause, 32'd11);
        chk("lit_ecall_count", 32'(trap_count), 32'd1);

        // MRET in range
        drive(1, 32'h1c09_0088, 0, 1, 0); #1;
        chk("lit_mret_redirect", {31'd0, redirect}, 32'd1);
        chk("lit_mret_rpc", redirect_pc, 32'h44);
        idle();
        chk("lit_mret_inhandler", {31'd0, in_handler}, 32'd0);
        chk("lit_mret_mepc", mepc, 32'h40);

        // Double fault
        drive(1, 32'h300, 1, 0, 0);
        drive(1, 32'h1c09_0010, 1, 0, 0); #1;
        chk("lit_dbl_redirect", {31'd0, redirect}, 32'd0);
        idle();
        chk("lit_dbl_halt", {31'd0, halt}, 32'd1);
        drive(1, 32'h40, 1, 0, 0); #1;
        chk("lit_fault_ecall", {31'd0, redirect}, 32'd0);
        drive(1, 32'h1c09_0000, 0, 1, 0); #1;
        chk("lit_fault_mret", {31'd0, redirect}, 32'd0);
        idle();
        chk("lit_fault_hold", {31'd0, halt}, 32'd1);
        do_reset();
        chk("lit_fault_clr", {31'd0, halt}, 32'd0);

        // Priority and MRET outside handler
        drive(1, 32'h100, 1, 0, 1);
        idle();
        chk("lit_ill_cause", mcause, 32'd2);
        chk("lit_ill_mepc", mepc, 32'h100);
        drive(1, 32'h1c09_0000, 0, 1, 0);
        drive(1, 32'h200, 0, 1, 0);
        idle();
        chk("lit_mret_run_cause", mcause, 32'd2);
        chk("lit_mret_run_mepc", mepc, 32'h200);
        drive(1, 32'h1c09_008c, 0, 1, 0);
        drive(0, 32'h300, 1, 0, 0); #1;
        chk("lit_noretire_redirect", {31'd0, redirect}, 32'd0);
        idle();
        chk("lit_noretire_inhandler", {31'd0, in_handler}, 32'd0);
        chk("lit_noretire_mepc", mepc, 32'h200);

        // One past the end of the ROM window
        drive(1, 32'h40, 1, 0, 0);
        drive(1, 32'h1c09_0090, 0, 0, 0);
        idle();
        chk("lit_oob_halt", {31'd0, halt}, 32'd1);
        do_reset();

        // Async reset mid-handler
        drive(1, 32'h80, 1, 0, 0);
        idle();
        @(posedge clk);
        #2;
        retire = 1'b1; pc = 32'h1c09_0004; mret = 1'b1;
        rst = 1'b1;
        #1;
        chk("lit_async_inhandler", {31'd0, in_handler}, 32'd0);
        chk("lit_async_mepc", mepc, 32'd0);
        chk("lit_async_redirect", {31'd0, redirect}, 32'd0);
        retire = 1'b0; mret = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Counter saturation
        for (int k = 0; k < (1 << CW) - 1; k++) begin
            drive(1, 32'h1000 + 32'(k) * 4, 1, 0, 0);
            drive(1, BASE + 32'h20, 0, 1, 0);
        end
        idle();
        chk("lit_sat_full", 32'(trap_count), 32'hff);
        drive(1, 32'h2000, 1, 0, 0);
        idle();
        chk("lit_sat_hold", 32'(trap_count), 32'hff);
        do_reset();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p;
            int sel;
            if (n % 60 == 59) begin
                do_reset();
            end else begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0:       p = $urandom;
                    1:       p = BASE - 32'd4;
                    2:       p = BASE + SIZE - 32'd4;
                    3:       p = BASE + SIZE;
                    4, 5:    p = 32'h100 + ($urandom_range(0, 255) << 2);
                    default: p = BASE + ($urandom_range(0, 35) << 2);
                endcase
                drive($urandom_range(0, 3) != 0, p,
                      $urandom_range(0, 6) == 0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 9) == 0);
            end
        end
        idle();
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
